// File: rtl/ray_dda_stepper.sv
// Integer-DDA ray walker that drives the 16x16 tile-map port and returns hit cell, side, type and distance.
// Optional macro RAY_BOUNDARY_WALL_EN: an exit off the map edge reports a type-1 wall hit instead of a miss.
module ray_dda_stepper #(
  parameter int DIST_W    = 16,
  parameter int MAX_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        start_x,
  input  logic [3:0]        start_y,
  input  logic              step_x_neg,
  input  logic              step_y_neg,
  input  logic [DIST_W-1:0] delta_x,
  input  logic [DIST_W-1:0] delta_y,
  input  logic [DIST_W-1:0] side_x_init,
  input  logic [DIST_W-1:0] side_y_init,
  output logic              busy,
  output logic [3:0]        map_x,
  output logic [3:0]        map_y,
  output logic              is_new_ray,
  input  logic [1:0]        is_wall,
  output logic              ray_done,
  output logic              hit,
  output logic              hit_side,
  output logic [3:0]        hit_x,
  output logic [3:0]        hit_y,
  output logic [1:0]        wall_type,
  output logic [DIST_W-1:0] perp_dist
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(MAX_STEPS - 1);

  typedef enum logic [2:0] {IDLE, INIT, QUERY, CHECK, DONE} state_t;

  state_t state_q, state_d;

  logic [DIST_W-1:0] side_x, side_y;
  logic [DIST_W-1:0] dx_q, dy_q;
  logic              xn_q, yn_q;
  logic [CNT_W-1:0]  count;
  logic              stepped;

  logic              wall_now, at_limit, take_x, at_edge;
  logic [DIST_W-1:0] side_x_add, side_y_add, perp_now, perp_edge;

  function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] a,
                                                input logic [DIST_W-1:0] b);
    logic [DIST_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DIST_W] ? {DIST_W{1'b1}} : s[DIST_W-1:0];
  endfunction

  // Per-cell decisions evaluated in CHECK; ties between side distances go to the y axis.
  always_comb begin
    wall_now   = (is_wall != 2'b00);
    at_limit   = (count == LAST_CELL);
    take_x     = (side_x < side_y);
    side_x_add = sat_add(side_x, dx_q);
    side_y_add = sat_add(side_y, dy_q);
    if (take_x) at_edge = xn_q ? (map_x == 4'd0) : (map_x == 4'd15);
    else        at_edge = yn_q ? (map_y == 4'd0) : (map_y == 4'd15);
    perp_now   = !stepped ? '0 : (hit_side ? side_y - dy_q : side_x - dx_q);
    perp_edge  = take_x ? side_x_add - dx_q : side_y_add - dy_q;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = QUERY;
      QUERY:   state_d = CHECK;
      CHECK:   state_d = (wall_now || at_limit || at_edge) ? DONE : QUERY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign is_new_ray = (state_q == INIT);
  assign ray_done   = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_x <= '0;  map_y <= '0;
      side_x <= '0; side_y <= '0;
      dx_q <= '0;   dy_q <= '0;
      xn_q <= 1'b0; yn_q <= 1'b0;
      count <= '0;  stepped <= 1'b0;
      hit <= 1'b0;  hit_side <= 1'b0;
      hit_x <= '0;  hit_y <= '0;
      wall_type <= '0; perp_dist <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          map_x <= start_x;      map_y <= start_y;
          side_x <= side_x_init; side_y <= side_y_init;
          dx_q <= delta_x;       dy_q <= delta_y;
          xn_q <= step_x_neg;    yn_q <= step_y_neg;
          count <= '0;  stepped <= 1'b0;
          hit <= 1'b0;  hit_side <= 1'b0;
          hit_x <= '0;  hit_y <= '0;
          wall_type <= '0; perp_dist <= '0;
        end
        CHECK: begin
          if (wall_now) begin
            hit       <= 1'b1;
            wall_type <= is_wall;
            perp_dist <= perp_now;
            hit_x     <= map_x;
            hit_y     <= map_y;
          end else if (at_limit) begin
            hit       <= 1'b0;
            perp_dist <= perp_now;
            hit_x     <= map_x;
            hit_y     <= map_y;
          end else if (at_edge) begin
`ifdef RAY_BOUNDARY_WALL_EN
            hit       <= 1'b1;
            wall_type <= 2'b01;
            hit_side  <= ~take_x;
            perp_dist <= perp_edge;
`else
            hit       <= 1'b0;
            perp_dist <= perp_now;
`endif
            hit_x     <= map_x;
            hit_y     <= map_y;
          end else begin
            if (take_x) begin
              side_x   <= side_x_add;
              map_x    <= xn_q ? map_x - 4'd1 : map_x + 4'd1;
              hit_side <= 1'b0;
            end else begin
              side_y   <= side_y_add;
              map_y    <= yn_q ? map_y - 4'd1 : map_y + 4'd1;
              hit_side <= 1'b1;
            end
            count   <= count + 1'b1;
            stepped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_dda_stepper.sv
// Scoreboard bench for ray_dda_stepper: directed rays against a fixed tile map, one default and one MAX_STEPS=4 instance.
module tb_ray_dda_stepper;

  typedef struct {
    logic        hit;
    logic        side;
    logic [3:0]  hx;
    logic [3:0]  hy;
    logic [1:0]  wt;
    logic [15:0] pd;
    int          done_cyc;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [3:0]  start_x = '0, start_y = '0;
  logic        step_x_neg = 1'b0, step_y_neg = 1'b0;
  logic [15:0] delta_x = '0, delta_y = '0, side_x_init = '0, side_y_init = '0;

  logic        busy_a, new_a, done_a, hit_a, side_a;
  logic [3:0]  mx_a, my_a, hx_a, hy_a;
  logic [1:0]  wall_a, wt_a;
  logic [15:0] pd_a;
  logic        busy_b, new_b, done_b, hit_b, side_b;
  logic [3:0]  mx_b, my_b, hx_b, hy_b;
  logic [1:0]  wall_b, wt_b;
  logic [15:0] pd_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   nr_cnt = 0;
  int   nr_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ray_dda_stepper dut_a (
    .clk(clk), .rst(rst), .start(start_a), .start_x(start_x), .start_y(start_y),
    .step_x_neg(step_x_neg), .step_y_neg(step_y_neg), .delta_x(delta_x), .delta_y(delta_y),
    .side_x_init(side_x_init), .side_y_init(side_y_init), .busy(busy_a), .map_x(mx_a),
    .map_y(my_a), .is_new_ray(new_a), .is_wall(wall_a), .ray_done(done_a), .hit(hit_a),
    .hit_side(side_a), .hit_x(hx_a), .hit_y(hy_a), .wall_type(wt_a), .perp_dist(pd_a)
  );

  ray_dda_stepper #(.MAX_STEPS(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_x(start_x), .start_y(start_y),
    .step_x_neg(step_x_neg), .step_y_neg(step_y_neg), .delta_x(delta_x), .delta_y(delta_y),
    .side_x_init(side_x_init), .side_y_init(side_y_init), .busy(busy_b), .map_x(mx_b),
    .map_y(my_b), .is_new_ray(new_b), .is_wall(wall_b), .ray_done(done_b), .hit(hit_b),
    .hit_side(side_b), .hit_x(hx_b), .hit_y(hy_b), .wall_type(wt_b), .perp_dist(pd_b)
  );

  function automatic logic [1:0] map_at(input logic [3:0] x, input logic [3:0] y);
    if (x == 4'd5 && y == 4'd2) return 2'd2;
    if (x == 4'd7 && y == 4'd7) return 2'd3;
    if (x == 4'd3 && y == 4'd4) return 2'd1;
    return 2'd0;
  endfunction

  // Registered map: response is valid one cycle after the address.
  always @(posedge clk) begin
    wall_a <= map_at(mx_a, my_a);
    wall_b <= map_at(mx_b, my_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_result(input string tag, input exp_t e, input logic h, input logic s,
                                input logic [3:0] hx, input logic [3:0] hy, input logic [1:0] wt,
                                input logic [15:0] pd);
    check({tag, "_cycle"}, 32'(cyc - e.acc + 1), 32'(e.done_cyc));
    check({tag, "_hit"}, 32'(h), 32'(e.hit));
    check({tag, "_side"}, 32'(s), 32'(e.side));
    check({tag, "_hit_x"}, 32'(hx), 32'(e.hx));
    check({tag, "_hit_y"}, 32'(hy), 32'(e.hy));
    check({tag, "_wall_type"}, 32'(wt), 32'(e.wt));
    check({tag, "_perp"}, 32'(pd), 32'(e.pd));
  endtask

  // Monitor for the default instance, also tracking the is_new_ray pulse of each ray.
  always @(negedge clk) begin
    if (!busy_a) nr_cnt = 0;
    if (new_a) begin
      nr_cnt++;
      nr_cyc = cyc;
    end
    if (done_a) begin
      if (q_a.size() == 0) check("spurious_ray_done_a", 32'(done_a), 32'd0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        compare_result("ray_a", e, hit_a, side_a, hx_a, hy_a, wt_a, pd_a);
        check("ray_a_new_ray_count", 32'(nr_cnt), 32'd1);
        check("ray_a_new_ray_cycle", 32'(nr_cyc - e.acc + 1), 32'd1);
        check("ray_a_busy_at_done", 32'(busy_a), 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (q_b.size() == 0) check("spurious_ray_done_b", 32'(done_b), 32'd0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        compare_result("ray_b", e, hit_b, side_b, hx_b, hy_b, wt_b, pd_b);
      end
    end
  end

  task automatic launch(input bit to_b, input logic [3:0] sx, input logic [3:0] sy,
                        input logic xn, input logic yn, input logic [15:0] dx, input logic [15:0] dy,
                        input logic [15:0] six, input logic [15:0] siy, input exp_t e, input bit push);
    exp_t ee;
    @(negedge clk);
    start_x = sx; start_y = sy; step_x_neg = xn; step_y_neg = yn;
    delta_x = dx; delta_y = dy; side_x_init = six; side_y_init = siy;
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    ee = e;
    ee.acc = cyc;
    if (push) begin
      if (to_b) q_b.push_back(ee); else q_a.push_back(ee);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      check("drain_timeout", 32'(q_a.size() + q_b.size()), 32'd0);
      q_a.delete();
      q_b.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  exp_t e_wall, e_start, e_edge, e_tie, e_diag, e_sat, e_none;

  initial begin
    e_wall  = '{hit:1'b1, side:1'b0, hx:4'd5,  hy:4'd2, wt:2'd2, pd:16'h0280, done_cyc:10, acc:0};
    e_start = '{hit:1'b1, side:1'b0, hx:4'd7,  hy:4'd7, wt:2'd3, pd:16'h0000, done_cyc:4,  acc:0};
`ifdef RAY_BOUNDARY_WALL_EN
    e_edge  = '{hit:1'b1, side:1'b0, hx:4'd15, hy:4'd7, wt:2'd1, pd:16'h0140, done_cyc:6,  acc:0};
    e_sat   = '{hit:1'b1, side:1'b1, hx:4'd9,  hy:4'd0, wt:2'd1, pd:16'h0007, done_cyc:4,  acc:0};
`else
    e_edge  = '{hit:1'b0, side:1'b0, hx:4'd15, hy:4'd7, wt:2'd0, pd:16'h0040, done_cyc:6,  acc:0};
    e_sat   = '{hit:1'b0, side:1'b0, hx:4'd9,  hy:4'd0, wt:2'd0, pd:16'h0000, done_cyc:4,  acc:0};
`endif
    e_tie   = '{hit:1'b1, side:1'b1, hx:4'd3,  hy:4'd4, wt:2'd1, pd:16'h0100, done_cyc:6,  acc:0};
    e_diag  = '{hit:1'b0, side:1'b1, hx:4'd1,  hy:4'd2, wt:2'd0, pd:16'h0180, done_cyc:10, acc:0};
    e_none  = '{hit:1'b0, side:1'b0, hx:4'd0,  hy:4'd0, wt:2'd0, pd:16'h0000, done_cyc:0,  acc:0};

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_map", 32'({mx_a, my_a}), 32'd0);
    check("reset_strobes", 32'({new_a, done_a}), 32'd0);
    check("reset_result", 32'({hit_a, side_a, hx_a, hy_a, wt_a}), 32'd0);
    check("reset_perp", 32'(pd_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    launch(1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 16'h0100, 16'hFFFF, 16'h0080, 16'hFFFF, e_wall, 1'b1);
    wait_drain();
    launch(1'b0, 4'd7, 4'd7, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0080, 16'h0080, e_start, 1'b1);
    wait_drain();
    launch(1'b0, 4'd14, 4'd7, 1'b0, 1'b0, 16'h0100, 16'hFFFF, 16'h0040, 16'hFFFF, e_edge, 1'b1);
    wait_drain();
    launch(1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, e_tie, 1'b1);
    wait_drain();
    launch(1'b0, 4'd9, 4'd0, 1'b0, 1'b1, 16'h0100, 16'hFFF8, 16'h0020, 16'h0010, e_sat, 1'b1);
    wait_drain();
    launch(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0080, 16'h0080, e_diag, 1'b1);
    wait_drain();

    // A second start during a ray must be ignored and must not disturb the result.
    launch(1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 16'h0100, 16'hFFFF, 16'h0080, 16'hFFFF, e_wall, 1'b1);
    repeat (2) @(negedge clk);
    start_x = 4'd7; start_y = 4'd7; step_x_neg = 1'b1; delta_x = 16'h0010; side_x_init = 16'h0001;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);

    // Reset in the middle of a ray abandons it without a ray_done.
    launch(1'b0, 4'd2, 4'd2, 1'b0, 1'b0, 16'h0100, 16'hFFFF, 16'h0080, 16'hFFFF, e_none, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check("midray_reset_busy", 32'(busy_a), 32'd0);
    check("midray_reset_map", 32'({mx_a, my_a}), 32'd0);
    check("midray_reset_strobes", 32'({new_a, done_a}), 32'd0);
    check("midray_reset_result", 32'({hit_a, side_a, hx_a, hy_a, wt_a, pd_a}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    launch(1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, e_tie, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ray_dda_stepper.md
Name: ray_dda_stepper

Overview:
Ray-marching initiator that drives the 16x16 tile-map lookup port.
- Accepts one ray per start: start cell, step signs, fixed-point DDA distances.
- Walks cells with integer DDA, issuing map_x/map_y and sampling the map's registered is_wall response.
- Returns the hit cell, hit side, wall type and perpendicular distance to the column renderer.
- Sits between the per-column ray setup logic and the map block.

Parameters:
- DIST_W, 16, width of all distance values; unsigned Q8.8 at the default.
- MAX_STEPS, 32, maximum number of cells examined per ray (including the start cell) before timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  ray request; sampled only in IDLE.
- start_x  in  4  starting map cell column.
- start_y  in  4  starting map cell row.
- step_x_neg  in  1  1 = step x by -1, 0 = by +1.
- step_y_neg  in  1  1 = step y by -1, 0 = by +1.
- delta_x  in  DIST_W  deltaDist along x.
- delta_y  in  DIST_W  deltaDist along y.
- side_x_init  in  DIST_W  initial sideDist x.
- side_y_init  in  DIST_W  initial sideDist y.
- busy  out  1  high from the start-accept cycle until ray_done.
- map_x  out  4  cell column presented to the map.
- map_y  out  4  cell row presented to the map.
- is_new_ray  out  1  one-cycle pulse telling the map a new ray begins.
- is_wall  in  2  map response; nonzero = wall; valid one cycle after map_x/map_y.
- ray_done  out  1  one-cycle result strobe.
- hit  out  1  1 = wall found, 0 = miss (edge or timeout).
- hit_side  out  1  0 = x-side face, 1 = y-side face.
- hit_x  out  4  last examined cell column.
- hit_y  out  4  last examined cell row.
- wall_type  out  2  is_wall value at the hit cell; 0 on a miss.
- perp_dist  out  DIST_W  perpendicular wall distance.

Behaviour:
Reset:
- Async reset on posedge rst puts the FSM in IDLE.
- All outputs go to 0; internal side_x/side_y and step counter go to 0.
- Reset mid-ray abandons the ray; no ray_done is produced.

States:
- IDLE: busy=0. On start=1:
  - load map_x/map_y from start_x/start_y.
  - load side distances from side_x_init/side_y_init.
  - clear step count, hit_side and result outputs; go to INIT.
  - start is ignored while busy.
- INIT: is_new_ray=1 for exactly this cycle; go to QUERY.
- QUERY: map_x/map_y are stable; go to CHECK.
- CHECK: is_wall now refers to the current cell.
  - If is_wall != 0: hit=1, wall_type=is_wall; go to DONE.
  - Else if count+1 == MAX_STEPS: hit=0; go to DONE.
  - Else take a DDA step:
    - if side_x < side_y: side_x += delta_x, move x, hit_side=0.
    - else (including a tie): side_y += delta_y, move y, hit_side=1.
    - Edge: a move from column 15 with +x, from 0 with -x, or the same on y leaves the map. Then do not move; hit=0; go to DONE.
    - Otherwise count++; go to QUERY.
- DONE: ray_done=1 for one cycle; hit_x/hit_y = map_x/map_y; go to IDLE.
  - Result outputs hold until the next start is accepted.

Distance and width rules:
- Side-distance additions saturate at all-ones; they never wrap.
- perp_dist = side of last stepped axis minus that axis's delta, and is 0 if no step was taken.
- Timeout and edge misses report perp_dist computed the same way.

Timing:
- Each cell costs 2 cycles.
- With start sampled at edge 0, ray_done is high in cycle 2+2N, where N = cells examined.

Optional Feature:
RAY_BOUNDARY_WALL_EN
- Defined: an edge exit reports hit=1 and wall_type=2'b01.
  - hit_side is the axis of the attempted step.
  - perp_dist is computed as if the step occurred, using the saturated add.
  - hit_x/hit_y stay at the last in-map cell.
- Undefined: an edge exit is a miss (hit=0, wall_type=0), as specified above.

Test Plan:
- Start (2,2), step +x, delta_x=0x0100, delta_y=0xFFFF, side_x_init=0x0080, side_y_init=0xFFFF, wall type 2 at (5,2) -> ray_done in cycle 10, hit=1, hit=(5,2), hit_side=0, wall_type=2, perp_dist=0x0280; is_new_ray pulsed only in cycle 1.
- Start cell (7,7) is a wall of type 3 -> ray_done in cycle 4, hit=1, perp_dist=0, hit_side=0, hit=(7,7).
- Start (14,7), step +x, empty row, macro off -> hit=0, hit_x=15, wall_type=0; macro on -> hit=1, wall_type=1, hit=(15,7).
- Tie: side_x_init=side_y_init=0x0100, delta 0x0100 both, wall at (3,4) from (3,3) with +y -> y step taken, hit_side=1, perp_dist=0x0100.
- MAX_STEPS=4, diagonal ray in an empty map from (0,0) -> hit=0 after 4 cells, ray_done in cycle 10.
- rst pulsed mid-ray -> outputs 0, no ray_done; start asserted while busy -> ignored, original ray result unchanged.
